spi_bank_loader: RTL and testbench
==================================

SPI_BANK_LOADER -- requirements
Module: spi_bank_loader

Interface
REQ-001 Parameter MEM_BW, 16, width of one deserialized SRAM word in bits.
REQ-002 Parameter MEM_DEPTH, 256, number of addressable words in the destination bank.
REQ-003 Parameter NUM_VALID_LINES, 256, words to load before completion (1..MEM_DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 sos  input  1  start-of-stream pulse, one cycle.
REQ-007 eos  input  1  end-of-stream pulse; aborts the load.
REQ-008 data_in  input  1  serial bit from the bank TX, one bit per clk.
REQ-009 wr_en  output  1  one-cycle SRAM write strobe.
REQ-010 wr_addr  output  $clog2(MEM_DEPTH)  SRAM write address.
REQ-011 wr_data  output  MEM_BW  SRAM write word.
REQ-012 busy  output  1  high while in SHIFT.
REQ-013 load_done  output  1  sticky completion flag.
REQ-014 err  output  1  sticky parity error flag (0 when SPI_LOADER_PARITY_EN undefined).

Function
REQ-015 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE->SHIFT on sos sampled high; bit counter, word counter, shift register, err cleared on that edge.
REQ-017 First payload bit sampled on the rising edge after the edge on which sos was sampled.
REQ-018 Bits shifted MSB first: shreg <= {shreg[MEM_BW-2:0], data_in}.
REQ-019 After the MEM_BW-th bit of a word, wr_en=1 for exactly the next cycle with wr_data = assembled word and wr_addr = word counter.
REQ-020 Word counter increments after each write; first word at address 0, no gaps.
REQ-021 Bit sampling continues without a bubble during the wr_en cycle (back-to-back words).
REQ-022 SHIFT->DONE on the cycle after the NUM_VALID_LINES-th write; load_done=1 in DONE.
REQ-023 eos in SHIFT -> DONE next cycle, partial word discarded, no write issued for it, load_done=1.
REQ-024 eos on the same edge that completes a word: that word is still written, then DONE.
REQ-025 sos in DONE -> SHIFT, load_done cleared, counters restart from 0 (reload).
REQ-026 sos in SHIFT is ignored; eos in IDLE or DONE is ignored.
REQ-027 wr_addr never exceeds NUM_VALID_LINES-1; no wrap-around write.
REQ-028 busy = (state == SHIFT); outputs registered, no combinational path from inputs.

Reset
REQ-029 reset low on a rising edge: state IDLE, wr_en 0, wr_addr 0, wr_data 0, busy 0, load_done 0, err 0, counters 0.
REQ-030 Reset mid-SHIFT abandons the load; no wr_en pulse in the cycle following reset release.

Configuration
REQ-031 Macro SPI_LOADER_PARITY_EN defined: each word followed by one even-parity bit (MEM_BW+1 bits/word); write still issued; mismatch sets err until next sos or reset.
REQ-032 Macro undefined: MEM_BW bits per word, no parity logic, err tied 0.

Structure
REQ-033 Shared package holds the loader state enum typedef and default bank constants (packet 16x256, neighbor-info 18x256).
REQ-034 One sub-module spi_deser_shift (shift register + bit counter, word_valid pulse) is natural; FSM and address counter stay in the top.

Verification
REQ-035 MEM_BW=16, NUM_VALID_LINES=3, words 0xA5A5,0x0001,0xFFFF after sos -> wr_en at addr 0,1,2 with those data, load_done high one cycle after third write.
REQ-036 eos after 8 bits of word 1 -> only addr 0 written, load_done=1, no further wr_en.
REQ-037 eos on word-0 completion edge -> addr 0 written with full word, then DONE.
REQ-038 reset low for one edge after 20 bits -> all outputs 0, no write; fresh sos reloads from addr 0.
REQ-039 sos in DONE with new stream 0x1234 -> load_done drops, addr 0 rewritten with 0x1234.
REQ-040 With SPI_LOADER_PARITY_EN, word 0x0003 with parity bit 1 -> write 0x0003, err=1 sticky; next sos clears err.

Source files
------------

// File: rtl/spi_bank_loader_pkg.sv
// Shared types and default bank geometry for the SPI bank loader.
// Optional even-parity framing is enabled by defining SPI_LOADER_PARITY_EN.
package spi_bank_loader_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } loader_state_e;

   // Packet bank and neighbor-info bank geometries
   localparam int unsigned PKT_BW    = 16;
   localparam int unsigned PKT_DEPTH = 256;
   localparam int unsigned NBR_BW    = 18;
   localparam int unsigned NBR_DEPTH = 256;

endpackage

// File: rtl/spi_bank_loader_deser.sv
// Serial-to-parallel word assembler (module spi_deser_shift): MSB-first shift register and bit counter.
// With SPI_LOADER_PARITY_EN each word carries one trailing even-parity bit.
module spi_deser_shift
   import spi_bank_loader_pkg::*;
#(
   parameter int unsigned MEM_BW = PKT_BW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic              data_in,
   output logic              word_done,
`ifdef SPI_LOADER_PARITY_EN
   output logic              parity_bad,
`endif
   output logic [MEM_BW-1:0] word_next
);

`ifdef SPI_LOADER_PARITY_EN
   localparam int unsigned BITS = MEM_BW + 1;
   localparam int unsigned SW   = MEM_BW;
`else
   localparam int unsigned BITS = MEM_BW;
   localparam int unsigned SW   = MEM_BW - 1;
`endif
   localparam int unsigned CW = $clog2(BITS);
   localparam logic [CW-1:0] LastBit = CW'(BITS - 1);

   logic [SW-1:0] shreg_q, shreg_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      word_done = enable && (bit_cnt_q == LastBit);
`ifdef SPI_LOADER_PARITY_EN
      // Parity bit is checked against the held word, not shifted in
      word_next  = shreg_q;
      parity_bad = (^shreg_q) ^ data_in;
      if (clear) begin
         shreg_d   = '0;
         bit_cnt_d = '0;
      end else if (enable) begin
         if (!word_done) shreg_d = {shreg_q[SW-2:0], data_in};
         bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
      end
`else
      word_next = {shreg_q, data_in};
      if (clear) begin
         shreg_d   = '0;
         bit_cnt_d = '0;
      end else if (enable) begin
         shreg_d   = word_next[MEM_BW-2:0];
         bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/spi_bank_loader.sv
// Loads a serial bit stream into an SRAM bank word by word, with sos/eos framing.
// Defining SPI_LOADER_PARITY_EN adds a per-word even-parity bit and the sticky err flag.
module spi_bank_loader
   import spi_bank_loader_pkg::*;
#(
   parameter int unsigned MEM_BW          = PKT_BW,
   parameter int unsigned MEM_DEPTH       = PKT_DEPTH,
   parameter int unsigned NUM_VALID_LINES = PKT_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sos,
   input  logic                         eos,
   input  logic                         data_in,
   output logic                         wr_en,
   output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
   output logic [MEM_BW-1:0]            wr_data,
   output logic                         busy,
   output logic                         load_done,
   output logic                         err
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] LastCnt = CW'(NUM_VALID_LINES);

   loader_state_e     state_q, state_d;
   logic [CW-1:0]     word_cnt_q, word_cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [MEM_BW-1:0] wr_data_q, wr_data_d;
   logic              eos_pend_q, eos_pend_d;
   logic              start, shift_en;
   logic              word_done;
   logic [MEM_BW-1:0] word_next;
`ifdef SPI_LOADER_PARITY_EN
   logic              parity_bad;
`endif

   spi_deser_shift #(
      .MEM_BW (MEM_BW)
   ) u_deser (
      .clk        (clk),
      .reset      (reset),
      .clear      (start),
      .enable     (shift_en),
      .data_in    (data_in),
      .word_done  (word_done),
`ifdef SPI_LOADER_PARITY_EN
      .parity_bad (parity_bad),
`endif
      .word_next  (word_next)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      eos_pend_d = eos_pend_q;
      start      = 1'b0;
      shift_en   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (sos) begin
               state_d    = StShift;
               start      = 1'b1;
               word_cnt_d = '0;
               eos_pend_d = 1'b0;
            end
         end
         StShift: begin
            shift_en = 1'b1;
            // Leave only once the final write strobe has been presented
            if (wr_en_q && ((word_cnt_q == LastCnt) || eos_pend_q)) begin
               state_d = StDone;
            end else if (word_done) begin
               wr_en_d    = 1'b1;
               wr_data_d  = word_next;
               wr_addr_d  = word_cnt_q[AW-1:0];
               word_cnt_d = word_cnt_q + CW'(1);
               if (eos) eos_pend_d = 1'b1;
            end else if (eos) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         eos_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         eos_pend_q <= eos_pend_d;
      end
   end

`ifdef SPI_LOADER_PARITY_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (start) begin
         err_q <= 1'b0;
      end else if (wr_en_d && parity_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = (state_q == StShift);
   assign load_done = (state_q == StDone);

endmodule

// File: tb/tb_spi_bank_loader.sv
// Randomized self-checking bench for spi_bank_loader against a stream-level model.
// Honours SPI_LOADER_PARITY_EN when the design is built with it.
module tb_spi_bank_loader;

   localparam int unsigned BW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned NVL   = 3;
`ifdef SPI_LOADER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int BITS = BW + (PAR ? 1 : 0);

   logic          clk = 1'b0;
   logic          reset, sos, eos, data_in;
   logic          wr_en, busy, load_done, err;
   logic [2:0]    wr_addr;
   logic [BW-1:0] wr_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Observed writes and load_done rising cycle
   int            wa_q[$];
   logic [BW-1:0] wd_q[$];
   int            wc_q[$];
   int            ld_rise = -1;
   logic          ld_prev = 1'b0;
   logic [BW-1:0] words[$];

   spi_bank_loader #(
      .MEM_BW          (BW),
      .MEM_DEPTH       (DEPTH),
      .NUM_VALID_LINES (NVL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sos       (sos),
      .eos       (eos),
      .data_in   (data_in),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .load_done (load_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wa_q.push_back(int'(wr_addr));
         wd_q.push_back(wr_data);
         wc_q.push_back(cyc);
      end
      if (load_done === 1'b1 && !ld_prev) ld_rise = cyc;
      ld_prev = (load_done === 1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One sos-framed load; eos_at/sos_at are payload bit indices (-1 = none)
   task automatic run_load(input string name, input int eos_at, input int sos_at, input int bad_w);
      logic          bits[$];
      logic [BW-1:0] w;
      int            e0, nw, exp_ld, navail;
      logic          exp_err;
      while (words.size() < NVL + 1) words.push_back(BW'($urandom));
      for (int k = 0; k < NVL + 1; k++) begin
         w = words[k];
         for (int b = BW - 1; b >= 0; b--) bits.push_back(w[b]);
         if (PAR) bits.push_back((^w) ^ (k == bad_w));
      end
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      ld_rise = -1;
      e0  = cyc;
      sos = 1'b1;
      step();
      sos = 1'b0;
      tests++;
      if (busy !== 1'b1 || load_done !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL %s start: busy=%b load_done=%b err=%b, required 1 0 0", name, busy,
                  load_done, err);
      end
      for (int j = 0; j < bits.size(); j++) begin
         data_in = bits[j];
         eos     = (j == eos_at);
         sos     = (j == sos_at);
         step();
      end
      data_in = 1'b0;
      eos     = 1'b0;
      sos     = 1'b0;
      repeat (3) step();

      // Model: words fully received before eos are written, capped at NVL
      navail = (eos_at >= 0) ? (eos_at + 1) / BITS : NVL;
      nw     = (navail < NVL) ? navail : NVL;
      if (nw == NVL || (eos_at >= 0 && (eos_at + 1) % BITS == 0)) exp_ld = e0 + 2 + nw * BITS;
      else exp_ld = e0 + 2 + eos_at;
      exp_err = PAR && (bad_w >= 0) && (bad_w < nw);

      tests++;
      if (wa_q.size() !== nw) begin
         fails++;
         $display("FAIL %s write_count: got %0d, required %0d", name, wa_q.size(), nw);
      end
      for (int k = 0; k < nw && k < wa_q.size(); k++) begin
         tests++;
         if (wa_q[k] !== k || wd_q[k] !== words[k] || wc_q[k] !== e0 + 1 + (k + 1) * BITS) begin
            fails++;
            $display("FAIL %s write%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                     name, k, wa_q[k], wd_q[k], wc_q[k], k, words[k], e0 + 1 + (k + 1) * BITS);
         end
      end
      tests++;
      if (ld_rise !== exp_ld) begin
         fails++;
         $display("FAIL %s load_done_rise: cyc %0d, required %0d", name, ld_rise, exp_ld);
      end
      tests++;
      if (load_done !== 1'b1 || busy !== 1'b0 || err !== exp_err) begin
         fails++;
         $display("FAIL %s final: load_done=%b busy=%b err=%b, required 1 0 %b", name, load_done,
                  busy, err, exp_err);
      end
      words.delete();
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      sos     = 1'b0;
      eos     = 1'b0;
      data_in = 1'b0;
      repeat (3) step();
      tests++;
      if ({wr_en, wr_addr, wr_data, busy, load_done, err} !== '0) begin
         fails++;
         $display("FAIL reset_state: wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
                  wr_en, wr_addr, wr_data, busy, load_done, err);
      end
      reset = 1'b1;
      repeat (2) step();
      tests++;
      if (busy !== 1'b0 || load_done !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_reset: busy=%b load_done=%b, required 0 0", busy, load_done);
      end
   endtask

   task automatic test_directed_load();
      words = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h5A5A};
      run_load("directed_load", -1, -1, -1);
   endtask

   task automatic test_eos_partial();
      run_load("eos_partial", BITS + 7, -1, -1);
   endtask

   task automatic test_eos_on_word();
      run_load("eos_on_word", BITS - 1, -1, -1);
   endtask

   task automatic test_reload();
      words = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'h0000};
      run_load("reload_from_done", -1, -1, -1);
   endtask

   task automatic test_sos_ignored();
      run_load("sos_in_shift", -1, 5, -1);
   endtask

   task automatic test_reset_mid();
      sos = 1'b1;
      step();
      sos = 1'b0;
      for (int j = 0; j < 20; j++) begin
         data_in = 1'($urandom);
         step();
      end
      wa_q.delete();
      reset = 1'b0;
      step();
      tests++;
      if ({wr_en, wr_addr, wr_data, busy, load_done, err} !== '0) begin
         fails++;
         $display("FAIL reset_mid_state: wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
                  wr_en, wr_addr, wr_data, busy, load_done, err);
      end
      reset = 1'b1;
      for (int j = 0; j < 4; j++) begin
         data_in = 1'($urandom);
         step();
      end
      tests++;
      if (wa_q.size() !== 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_quiet: writes=%0d busy=%b, required 0 0", wa_q.size(), busy);
      end
      run_load("reload_after_reset", -1, -1, -1);
   endtask

   task automatic test_parity();
      words = '{16'h0003, 16'h8001, 16'h7FFF, 16'h0000};
      run_load("parity_bad_word0", -1, -1, 0);
      run_load("parity_clean", -1, -1, -1);
   endtask

   task automatic test_random();
      int eos_at, sos_at, limit, bad_w;
      for (int it = 0; it < 8; it++) begin
         eos_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NVL * BITS + 2));
         limit  = (eos_at >= 0) ? eos_at : NVL * BITS;
         sos_at = ($urandom_range(0, 1) == 0 || limit == 0) ? -1 : int'($urandom_range(0, limit - 1));
         bad_w  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, NVL - 1));
         run_load("random", eos_at, sos_at, bad_w);
      end
   endtask

   initial begin
      test_reset();
      test_directed_load();
      test_eos_partial();
      test_eos_on_word();
      test_reload();
      test_sos_ignored();
      test_reset_mid();
      test_parity();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
